// File: rtl/dcr_pkg.sv
// Shared definitions for the device control register bank: register
// indices, CTRL/STATUS bit positions and the launch FSM state type.
package dcr_pkg;

  // Register map indices
  localparam int CTRL         = 0;
  localparam int STATUS       = 1;
  localparam int THREAD_COUNT = 2;
  localparam int ARG_BASE     = 3;

  // CTRL write-1 action bits
  localparam int CTRL_START_BIT    = 0;
  localparam int CTRL_CLR_DONE_BIT = 1;
  localparam int CTRL_CLR_ERR_BIT  = 2;

  // STATUS read-only bits
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
  localparam int STATUS_ERR_BIT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2
  } dcr_state_t;

  // True when a register index addresses one of the ARG registers
  function automatic logic is_arg_index(input int idx, input int num_regs);
    return (idx >= ARG_BASE) && (idx < num_regs);
  endfunction

endpackage

// File: rtl/dcr_bank.sv
// Device control register bank: host-writable configuration registers
// (THREAD_COUNT, ARG0..ARGn), a read-only STATUS word, write-1 CTRL actions
// and the kernel launch handshake toward the dispatcher.
//
// Build option: define DCR_WRITE_LOCK_EN to drop THREAD_COUNT/ARG writes
// while a kernel is in flight (and flag err), keeping the configuration
// outputs frozen for the whole kernel.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no kernel in flight; START may launch
// ST_LAUNCH | launch_valid held high until the dispatcher takes it
// ST_BUSY   | kernel running; waits for the kernel_done pulse
module dcr_bank
  import dcr_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 4,
  localparam int ADDR_W   = $clog2(NUM_REGS),
  localparam int NUM_ARGS = NUM_REGS - 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          thread_count,
  output logic [NUM_ARGS*DATA_W-1:0] cfg_args,
  output logic                       launch_valid,
  input  logic                       launch_ready,
  input  logic                       kernel_done,
  output logic                       busy
);

  dcr_state_t        state_q, state_d;
  logic [DATA_W-1:0] thread_count_q, thread_count_d;
  logic [DATA_W-1:0] args_q [NUM_ARGS];
  logic [DATA_W-1:0] args_d [NUM_ARGS];
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              launch_valid_q, launch_valid_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic                wr_ctrl;
  logic                start;
  logic                clr_done;
  logic                clr_err;
  logic                wr_tc_hit;
  logic [NUM_ARGS-1:0] wr_arg_hit;
  logic                cfg_wr;
  logic                cfg_wr_ok;
  logic                lock_err;
  logic                set_done;
  logic                start_clr_done;
  logic                set_err;
  logic [DATA_W-1:0]   rd_mux;

  // Write address decode and CTRL action strobes
  always_comb begin
    wr_ctrl   = wr_en && (wr_addr == ADDR_W'(CTRL));
    start     = wr_ctrl && wr_data[CTRL_START_BIT];
    clr_done  = wr_ctrl && wr_data[CTRL_CLR_DONE_BIT];
    clr_err   = wr_ctrl && wr_data[CTRL_CLR_ERR_BIT];
    wr_tc_hit = wr_en && (wr_addr == ADDR_W'(THREAD_COUNT));
    wr_arg_hit = '0;
    for (int i = 0; i < NUM_ARGS; i++) begin
      if (is_arg_index(ARG_BASE + i, NUM_REGS)) begin
        wr_arg_hit[i] = wr_en && (wr_addr == ADDR_W'(ARG_BASE + i));
      end
    end
    cfg_wr = wr_tc_hit || (|wr_arg_hit);
  end

  // Configuration write gating while a kernel is in flight
  always_comb begin
`ifdef DCR_WRITE_LOCK_EN
    cfg_wr_ok = cfg_wr && !busy_q;
    lock_err  = cfg_wr && busy_q;
`else
    cfg_wr_ok = cfg_wr;
    lock_err  = 1'b0;
`endif
  end

  // Configuration register next-state
  always_comb begin
    thread_count_d = thread_count_q;
    for (int i = 0; i < NUM_ARGS; i++) begin
      args_d[i] = args_q[i];
    end
    if (cfg_wr_ok && wr_tc_hit) begin
      thread_count_d = wr_data;
    end
    for (int i = 0; i < NUM_ARGS; i++) begin
      if (cfg_wr_ok && wr_arg_hit[i]) begin
        args_d[i] = wr_data;
      end
    end
  end

  // Launch FSM next-state and sticky flag events
  always_comb begin
    state_d        = state_q;
    set_done       = 1'b0;
    start_clr_done = 1'b0;
    set_err        = lock_err;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (thread_count_q != '0) begin
            state_d        = ST_LAUNCH;
            start_clr_done = 1'b1;
          end else begin
            // Nothing to run: report completion without a launch
            set_done = 1'b1;
          end
        end
      end
      ST_LAUNCH: begin
        if (launch_ready) begin
          state_d = ST_BUSY;
        end
        if (start) begin
          set_err = 1'b1;
        end
      end
      ST_BUSY: begin
        if (kernel_done) begin
          state_d  = ST_IDLE;
          set_done = 1'b1;
        end
        if (start) begin
          set_err = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky flags (a set in the same cycle as a clear wins) and registered outputs
  always_comb begin
    done_d = done_q;
    if (set_done) begin
      done_d = 1'b1;
    end else if (start_clr_done || clr_done) begin
      done_d = 1'b0;
    end
    err_d = err_q;
    if (set_err) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
    launch_valid_d = (state_d == ST_LAUNCH);
    busy_d         = (state_d != ST_IDLE);
  end

  // Read mux on current (pre-write) state; out-of-range and CTRL read as 0
  always_comb begin
    rd_mux = '0;
    if (rd_addr == ADDR_W'(STATUS)) begin
      rd_mux[STATUS_BUSY_BIT] = busy_q;
      rd_mux[STATUS_DONE_BIT] = done_q;
      rd_mux[STATUS_ERR_BIT]  = err_q;
    end else if (rd_addr == ADDR_W'(THREAD_COUNT)) begin
      rd_mux = thread_count_q;
    end
    for (int i = 0; i < NUM_ARGS; i++) begin
      if (rd_addr == ADDR_W'(ARG_BASE + i)) begin
        rd_mux = args_q[i];
      end
    end
    rd_valid_d = rd_en;
    rd_data_d  = rd_en ? rd_mux : rd_data_q;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      thread_count_q <= '0;
      for (int i = 0; i < NUM_ARGS; i++) begin
        args_q[i] <= '0;
      end
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
      launch_valid_q <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      thread_count_q <= thread_count_d;
      for (int i = 0; i < NUM_ARGS; i++) begin
        args_q[i] <= args_d[i];
      end
      done_q         <= done_d;
      err_q          <= err_d;
      busy_q         <= busy_d;
      launch_valid_q <= launch_valid_d;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
    end
  end

  // Flatten ARG registers, ARG0 in the LSBs
  always_comb begin
    cfg_args = '0;
    for (int i = 0; i < NUM_ARGS; i++) begin
      cfg_args[i*DATA_W +: DATA_W] = args_q[i];
    end
  end

  assign thread_count = thread_count_q;
  assign launch_valid = launch_valid_q;
  assign busy         = busy_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_dcr_bank.sv
// Self-checking bench for dcr_bank: directed scenarios plus randomized
// traffic against a behavioural model; read responses go through a
// scoreboard queue checked by a separate monitor process.
module tb_dcr_bank;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int AW = 2;
  localparam int NA = NR - 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [DW-1:0] thread_count;
  logic [NA*DW-1:0] cfg_args;
  logic          launch_valid;
  logic          launch_ready;
  logic          kernel_done;
  logic          busy;

  always #5 clk = ~clk;

  dcr_bank #(.DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .thread_count (thread_count),
    .cfg_args     (cfg_args),
    .launch_valid (launch_valid),
    .launch_ready (launch_ready),
    .kernel_done  (kernel_done),
    .busy         (busy)
  );

  // Behavioural model: register contents, request/running phase, sticky flags
  logic [DW-1:0] m_tc;
  logic [DW-1:0] m_args [NA];
  bit m_req, m_run, m_done, m_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [DW-1:0] last_rd = '0;

  typedef struct {
    int            due;
    logic [DW-1:0] val;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    int idx;
    idx = int'(a);
    if (idx == 1) return {5'b0, m_err, m_done, (m_req || m_run)};
    if (idx == 2) return m_tc;
    if (idx >= 3 && idx < NR) return m_args[idx - 3];
    return '0;
  endfunction

  // Apply the inputs currently driven, as seen by the next rising edge
  task automatic model_edge();
    bit was_busy, start, cd, ce, sd, se, cs;
    if (!reset_n) begin
      m_tc = '0;
      for (int i = 0; i < NA; i++) m_args[i] = '0;
      m_req = 0; m_run = 0; m_done = 0; m_err = 0;
      return;
    end
    was_busy = m_req || m_run;
    start = wr_en && (wr_addr == 0) && wr_data[0];
    cd    = wr_en && (wr_addr == 0) && wr_data[1];
    ce    = wr_en && (wr_addr == 0) && wr_data[2];
    sd = 0; se = 0; cs = 0;
    if (m_req) begin
      if (launch_ready) begin m_req = 0; m_run = 1; end
    end else if (m_run) begin
      if (kernel_done) begin m_run = 0; sd = 1; end
    end
    if (start) begin
      if (was_busy) se = 1;
      else if (m_tc != 0) begin m_req = 1; cs = 1; end
      else sd = 1;
    end
    if (wr_en && wr_addr >= 2) begin
`ifdef DCR_WRITE_LOCK_EN
      if (was_busy) se = 1;
      else if (wr_addr == 2) m_tc = wr_data;
      else m_args[int'(wr_addr) - 3] = wr_data;
`else
      if (wr_addr == 2) m_tc = wr_data;
      else m_args[int'(wr_addr) - 3] = wr_data;
`endif
    end
    if (sd) m_done = 1; else if (cs || cd) m_done = 0;
    if (se) m_err = 1; else if (ce) m_err = 0;
  endtask

  // One clock: queue expected read, advance model, check outputs, release strobes
  task automatic tick(input bit has_const = 0, input logic [DW-1:0] cval = '0);
    exp_t e;
    if (reset_n && rd_en) begin
      e.due = cyc + 1;
      e.val = has_const ? cval : model_read(rd_addr);
      exp_q.push_back(e);
    end
    model_edge();
    @(posedge clk);
    #1;
    if (!reset_n) last_rd = '0;
    chk("launch_valid", launch_valid, m_req);
    chk("busy", busy, m_req || m_run);
    chk("thread_count", thread_count, m_tc);
    chk("cfg_args", cfg_args, m_args[0]);
    wr_en = 0;
    rd_en = 0;
    kernel_done = 0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
  endtask

  task automatic rd_const(input logic [AW-1:0] a, input logic [DW-1:0] v);
    rd_en = 1; rd_addr = a;
    tick(1, v);
  endtask

  int lv_cnt;

  initial begin
    reset_n = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    rd_en = 0; rd_addr = '0; launch_ready = 0; kernel_done = 0;

    // Read-response monitor, independent of the stimulus flow
    fork
      forever begin
        @(negedge clk);
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          chk("rd_response_missing", 32'd1, 32'd0);
          void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rd_valid", rd_valid, 1'b1);
          chk("rd_data", rd_data, e.val);
          last_rd = e.val;
        end else begin
          chk("rd_valid_idle", rd_valid, 1'b0);
          chk("rd_data_hold", rd_data, last_rd);
        end
      end
    join_none

    tick(); tick();
    reset_n = 1;

    // Reset clears registers and handshake
    wr(2, 8'h10);
    reset_n = 0; tick(); reset_n = 1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_launch_valid", launch_valid, 1'b0);
    rd_const(2, 8'h00);

    // Launch with dispatcher stalling three cycles
    wr(2, 8'h08);
    launch_ready = 0;
    lv_cnt = 0;
    wr(0, 8'h01);
    lv_cnt += int'(launch_valid);
    chk("launch_busy", busy, 1'b1);
    repeat (3) begin tick(); lv_cnt += int'(launch_valid); end
    launch_ready = 1;
    tick(); lv_cnt += int'(launch_valid);
    chk("launch_valid_cycles", lv_cnt, 4);
    chk("busy_after_accept", busy, 1'b1);
    kernel_done = 1; tick();
    rd_const(1, 8'h02);

    // Zero thread count: no launch, done immediately
    wr(0, 8'h02);
    rd_const(1, 8'h00);
    wr(2, 8'h00);
    wr(0, 8'h01);
    chk("zero_tc_no_launch", launch_valid, 1'b0);
    rd_const(1, 8'h02);

    // START while busy, CLR_ERR, CLR_DONE racing kernel_done
    wr(2, 8'h08);
    launch_ready = 1;
    wr(0, 8'h01);
    tick();
    wr(0, 8'h01);
    rd_const(1, 8'h05);
    wr(0, 8'h04);
    rd_const(1, 8'h01);
    wr_en = 1; wr_addr = 0; wr_data = 8'h02; kernel_done = 1; tick();
    rd_const(1, 8'h02);

    // Configuration write during a kernel
    wr(0, 8'h06);
    wr(3, 8'hAA);
    wr(0, 8'h01);
    tick();
    wr(3, 8'h55);
`ifdef DCR_WRITE_LOCK_EN
    chk("locked_arg0", cfg_args[7:0], 8'hAA);
    rd_const(1, 8'h05);
`else
    chk("unlocked_arg0", cfg_args[7:0], 8'h55);
    rd_const(1, 8'h01);
`endif
    kernel_done = 1; tick();

    // Readback, CTRL reads zero, read-during-write returns old value
    wr(3, 8'h3C);
    rd_const(3, 8'h3C);
    rd_const(0, 8'h00);
    wr_en = 1; wr_addr = 2; wr_data = 8'h77; rd_en = 1; rd_addr = 2;
    tick(1, 8'h08);
    rd_const(2, 8'h77);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      reset_n      = ($urandom_range(0, 99) != 0);
      wr_en        = $urandom_range(0, 1);
      wr_addr      = AW'($urandom_range(0, NR - 1));
      wr_data      = (wr_addr == 0) ? DW'($urandom_range(0, 7)) : DW'($urandom);
      rd_en        = $urandom_range(0, 1);
      rd_addr      = AW'($urandom_range(0, NR - 1));
      launch_ready = $urandom_range(0, 1);
      kernel_done  = ($urandom_range(0, 3) == 0);
      tick();
    end
    reset_n = 1;
    launch_ready = 0;
    tick(); tick(); tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
